// File: rtl/mem_banked.sv
// rtl/mem_banked.sv - banked word memory with byte enables, registered read and zero-fill init
module mem_banked #(
    parameter int DATA_W     = 32,
    parameter int BANK_SEL_W = 3,
    parameter int BANK_AW    = 15,
    parameter int INIT_CLEAR = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BANK_SEL_W+BANK_AW-1:0] dira,
    input  logic [DATA_W-1:0]             write_data,
    input  logic [DATA_W/8-1:0]           byte_en,
    input  logic                          memwrite,
    input  logic                          memread,
    output logic                          ready,
    output logic [DATA_W-1:0]             out,
    output logic                          out_valid
);

    localparam int NB     = 2 ** BANK_SEL_W;
    localparam int DEPTH  = 2 ** BANK_AW;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [BANK_AW-1:0]      init_cnt;
    logic [BANK_AW-1:0]      init_cnt_nxt;
    logic [BANK_SEL_W-1:0]   sel_bank;
    logic [BANK_AW-1:0]      sel_word;
    logic [BANK_SEL_W-1:0]   rd_bank;
    logic                    clear_en;
    logic                    req_wr;
    logic                    req_rd;
    logic [NB-1:0][DATA_W-1:0] rd_all;

    assign sel_bank = dira[BANK_SEL_W+BANK_AW-1:BANK_AW];
    assign sel_word = dira[BANK_AW-1:0];

    // Requests are only honoured once the fill is done; reset blocks everything.
    assign clear_en = !rst && (state == ST_INIT) && (INIT_CLEAR != 0);
    assign req_wr   = !rst && (state == ST_IDLE) && memwrite;
    assign req_rd   = !rst && (state == ST_IDLE) && memread && !memwrite;
    assign ready    = (state == ST_IDLE);

    // State register and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next-state: walk every word index once when clearing, else go straight to IDLE.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            ST_INIT: begin
                if (INIT_CLEAR == 0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                    if (init_cnt == {BANK_AW{1'b1}}) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Read strobe and the bank index that steers the output mux one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd_bank   <= '0;
        end else begin
            out_valid <= req_rd;
            if (req_rd) begin
                rd_bank <= sel_bank;
            end
        end
    end

    genvar b;
    generate
        for (b = 0; b < NB; b++) begin : g_bank
            logic [DATA_W-1:0] bank_mem [DEPTH];
            logic [DATA_W-1:0] rd_q;

            // Storage: all banks cleared in parallel during INIT, else only the addressed bank written.
            always_ff @(posedge clk) begin
                if (clear_en) begin
                    bank_mem[init_cnt] <= '0;
                end else if (req_wr && (sel_bank == BANK_SEL_W'(b))) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (byte_en[i]) begin
                            bank_mem[sel_word][8*i +: 8] <= write_data[8*i +: 8];
                        end
                    end
                end
            end

            // Per-bank read register; holds its value between reads so out stays stable.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (req_rd && (sel_bank == BANK_SEL_W'(b))) begin
                    rd_q <= bank_mem[sel_word];
                end
            end

            assign rd_all[b] = rd_q;
        end
    endgenerate

    assign out = rd_all[rd_bank];

endmodule

// File: doc/mem_banked.md
Name: mem_banked

Overview:
Parametrised banked word memory: 2**BANK_SEL_W banks of 2**BANK_AW words each, DATA_W wide. Upper address bits select the bank; lower bits select the word within it. Adds capabilities the fixed 8-bank, 32-bit store lacks: byte-enable writes, registered read data with a valid strobe, a ready flag, and optional zero-fill after reset. It sits behind the datapath load/store stage as data or instruction storage.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
BANK_SEL_W, 3, bank-select bits; bank count = 2**BANK_SEL_W.
BANK_AW, 15, word-address bits per bank; bank depth = 2**BANK_AW.
INIT_CLEAR, 1, 1 = zero-fill all banks after reset; 0 = skip the fill and keep existing contents.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
dira  input  BANK_SEL_W+BANK_AW  word address; [MSBs] = bank, [BANK_AW-1:0] = word.
write_data  input  DATA_W  write data.
byte_en  input  DATA_W/8  per-byte write enable; bit i covers bits [8i+7:8i].
memwrite  input  1  write request.
memread  input  1  read request.
ready  output  1  high when requests are accepted.
out  output  DATA_W  registered read data.
out_valid  output  1  one-cycle strobe: out holds fresh read data.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- States: INIT, IDLE. Internal init_cnt is BANK_AW bits wide.
- Reset: rst=1 at an edge sets state=INIT, init_cnt=0, ready=0, out=0, out_valid=0. Holding rst keeps these values. Memory is not written while rst=1.
- INIT with INIT_CLEAR=1:
  - Each edge with rst=0 writes zero to word init_cnt in every bank at once, then increments init_cnt.
  - On the edge that clears init_cnt = 2**BANK_AW-1, state goes to IDLE and ready goes to 1.
  - ready therefore rises after exactly 2**BANK_AW edges with rst low.
- INIT with INIT_CLEAR=0: the first edge with rst=0 goes to IDLE, and ready=1 after that edge. Contents are unspecified.
- While ready=0, memread, memwrite, dira, write_data and byte_en are ignored. No memory write occurs and out_valid stays 0.
- Write (ready=1, memwrite=1 at edge t):
  - For each byte i with byte_en[i]=1, mem[dira] byte i takes write_data byte i.
  - Bytes with byte_en[i]=0 are unchanged. byte_en=0 is a no-op write.
  - out_valid=0 after edge t.
- Read (ready=1, memread=1, memwrite=0 at edge t):
  - After edge t, out = mem[dira] as it stood before edge t, and out_valid=1 for that one cycle.
  - Latency is one cycle. A read at edge t+1 of a word written at edge t returns the new data.
- Back-to-back reads: one read per cycle, with no bubbles. out_valid stays high across consecutive read cycles, and data returns in request order.
- Simultaneous memread=1 and memwrite=1: the write wins and is performed as above. The read is dropped and out_valid=0.
- No request: out_valid=0 and out holds its last value.
- Reset mid-operation:
  - A pending out_valid is cleared next cycle; out is forced to 0.
  - An in-progress INIT restarts from init_cnt=0.
  - With INIT_CLEAR=1 all contents are re-zeroed.
- Bank decode: bank b = dira[BANK_SEL_W+BANK_AW-1:BANK_AW].
  - Only bank b is write-enabled for a request; all banks are enabled during INIT.
  - Read mux select is the registered bank index, so the output path stays aligned with the one-cycle latency.
- The address space is always fully populated; there is no out-of-range condition.

Test Plan:
(Bench parameters: DATA_W=32, BANK_SEL_W=2, BANK_AW=4, INIT_CLEAR=1.)
- Hold rst for 3 edges, then release -> ready=0 for exactly 16 edges, then 1. memwrite pulses during INIT cause no write, and reading 0x25 afterwards returns 0x00000000.
- Write 0xDEADBEEF to 0x25 with be=4'b1111, then read 0x25 -> out=0xDEADBEEF with out_valid=1 for one cycle. Read 0x05 (bank 0, same word) -> 0x00000000, proving bank isolation.
- Over 0xDEADBEEF at 0x25, write 0x11223344 with be=4'b0101, then read -> out=0xDE22BE44.
- Assert memread=1 and memwrite=1 to 0x3F with data 0xCAFEF00D, be=4'b1111 -> out_valid=0 that cycle. A later read of 0x3F returns 0xCAFEF00D.
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x11, 0x22, 0x33, then read those addresses on 4 consecutive cycles -> out_valid high for 4 consecutive cycles with out = 1, 2, 3, 4 in order.
- Assert rst in the cycle after a read request to a nonzero word -> out_valid=0 and out=0 next cycle, ready=0. After 16 edges ready=1 and all four written words read back 0.
